// File: rtl/icache_nway_if.sv
// Fetch, CACHE-op and AXI-bridge signal bundle of the N-way instruction cache.
// The cache takes the slave side; the fetch stage and bridge take the master side.
interface icache_nway_if #(
    parameter int unsigned TAG_W  = 20,
    parameter int unsigned LINE_W = 128
);
    logic              req;
    logic [31:0]       addr;
    logic              uncached;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;

    logic              cop_valid;
    logic [1:0]        cop_code;
    logic [31:0]       cop_addr;
    logic [TAG_W-1:0]  cop_tag;
    logic              cop_v;
    logic              cop_done;

    logic              rd_req;
    logic              rd_uncache;
    logic [31:0]       rd_addr;
    logic              rd_rdy;
    logic              ret_valid;
    logic [LINE_W-1:0] ret_data;

    modport slave (
        input  req, addr, uncached, cop_valid, cop_code, cop_addr, cop_tag, cop_v,
               rd_rdy, ret_valid, ret_data,
        output addr_ok, data_ok, rdata, cop_done, rd_req, rd_uncache, rd_addr
    );

    modport master (
        output req, addr, uncached, cop_valid, cop_code, cop_addr, cop_tag, cop_v,
               rd_rdy, ret_valid, ret_data,
        input  addr_ok, data_ok, rdata, cop_done, rd_req, rd_uncache, rd_addr
    );
endinterface

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with per-set round-robin
// replacement, post-reset invalidate sweep and handshaked CACHE ops.
module icache_nway #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned LINE_WORD_NUM = 4,
    parameter int unsigned ASSOC_NUM     = 2,
    parameter int unsigned WAY_SIZE      = 32768
) (
    input  logic         clk_g,
    input  logic         resetn,
    icache_nway_if.slave bus
);
    localparam int unsigned GROUP_NUM = WAY_SIZE / (LINE_WORD_NUM * DATA_WIDTH);
    localparam int unsigned OFFSET_W  = $clog2(LINE_WORD_NUM * 4);
    localparam int unsigned INDEX_W   = $clog2(GROUP_NUM);
    localparam int unsigned TAG_W     = 32 - INDEX_W - OFFSET_W;
    localparam int unsigned WAY_W     = (ASSOC_NUM > 1) ? $clog2(ASSOC_NUM) : 1;
    localparam int unsigned LINE_W    = LINE_WORD_NUM * DATA_WIDTH;
    localparam int unsigned WORD_W    = OFFSET_W - 2;

    typedef enum logic [2:0] {
        ST_INIT, ST_LOOKUP, ST_MISS, ST_REFILL, ST_RESP, ST_COP
    } state_t;

    state_t               r_state;
    logic [INDEX_W-1:0]   r_init_cnt;
    logic [WAY_W-1:0]     r_rr [GROUP_NUM];

    logic                 r_busy;
    logic [31:0]          r_addr;
    logic                 r_unc;
    logic [31:0]          r_resp_word;

    logic [1:0]           r_cop_code;
    logic [INDEX_W-1:0]   r_cop_idx;
    logic [TAG_W-1:0]     r_cop_cmp_tag;
    logic [WAY_W-1:0]     r_cop_way;
    logic [TAG_W-1:0]     r_cop_tag;
    logic                 r_cop_v;
    logic                 r_cop_done;

    logic                 r_rd_req;
    logic                 r_rd_uncache;
    logic [31:0]          r_rd_addr;

    logic [TAG_W:0]       r_tag_mem  [ASSOC_NUM][GROUP_NUM];
    logic [LINE_W-1:0]    r_data_mem [ASSOC_NUM][GROUP_NUM];
    logic [TAG_W:0]       r_tag_q    [ASSOC_NUM];
    logic [LINE_W-1:0]    r_data_q   [ASSOC_NUM];

    logic [TAG_W-1:0]     w_req_tag;
    logic [INDEX_W-1:0]   w_req_idx;
    logic [WORD_W-1:0]    w_req_word;
    logic [OFFSET_W+2:0]  w_word_base;
    logic [INDEX_W-1:0]   w_rd_idx;
    logic [TAG_W-1:0]     w_cmp_tag;
    logic                 w_hit_any;
    logic [WAY_W-1:0]     w_hit_way;
    logic                 w_lookup_hit;
    logic                 w_addr_ok;
    logic [WAY_W-1:0]     w_victim;
    logic                 w_cop_we;
    logic [WAY_W-1:0]     w_cop_wway;
    logic [TAG_W:0]       w_cop_wdata;

    assign w_req_tag   = r_addr[31 -: TAG_W];
    assign w_req_idx   = r_addr[OFFSET_W +: INDEX_W];
    assign w_req_word  = r_addr[2 +: WORD_W];
    assign w_word_base = {w_req_word, 5'd0};
    assign w_rd_idx    = bus.cop_valid ? bus.cop_addr[OFFSET_W +: INDEX_W]
                                       : bus.addr[OFFSET_W +: INDEX_W];
    assign w_cmp_tag   = (r_state == ST_COP) ? r_cop_cmp_tag : w_req_tag;
    assign w_victim    = r_rr[w_req_idx];

    // Shared tag compare; descending scan so the lowest matching way wins.
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_way = '0;
        for (int w = ASSOC_NUM - 1; w >= 0; w--) begin
            if (r_tag_q[w][TAG_W] && (r_tag_q[w][TAG_W-1:0] == w_cmp_tag)) begin
                w_hit_any = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    assign w_lookup_hit = (r_state == ST_LOOKUP) && r_busy && !r_unc && w_hit_any;
    assign w_addr_ok    = resetn && (r_state == ST_LOOKUP) && !bus.cop_valid &&
                          (!r_busy || w_lookup_hit);

    always_comb begin
        w_cop_we    = 1'b0;
        w_cop_wway  = r_cop_way;
        w_cop_wdata = {1'b0, r_tag_q[r_cop_way][TAG_W-1:0]};
        case (r_cop_code)
            2'd0: w_cop_we = 1'b1;
            2'd1: begin
                w_cop_we    = 1'b1;
                w_cop_wdata = {r_cop_v, r_cop_tag};
            end
            2'd2: begin
                w_cop_we    = w_hit_any;
                w_cop_wway  = w_hit_way;
                w_cop_wdata = {1'b0, r_tag_q[w_hit_way][TAG_W-1:0]};
            end
            default: w_cop_we = 1'b0;
        endcase
    end

    // Arrays: synchronous read in LOOKUP, writes gated off while reset is held.
    always_ff @(posedge clk_g) begin
        if (r_state == ST_LOOKUP) begin
            for (int unsigned w = 0; w < ASSOC_NUM; w++) begin
                r_tag_q[w]  <= r_tag_mem[w][w_rd_idx];
                r_data_q[w] <= r_data_mem[w][w_rd_idx];
            end
        end
        if (resetn) begin
            if (r_state == ST_INIT) begin
                for (int unsigned w = 0; w < ASSOC_NUM; w++) begin
                    r_tag_mem[w][r_init_cnt] <= '0;
                end
            end
            if ((r_state == ST_REFILL) && bus.ret_valid && !r_unc) begin
                r_tag_mem[w_victim][w_req_idx]  <= {1'b1, w_req_tag};
                r_data_mem[w_victim][w_req_idx] <= bus.ret_data;
            end
            if ((r_state == ST_COP) && w_cop_we) begin
                r_tag_mem[w_cop_wway][r_cop_idx] <= w_cop_wdata;
            end
        end
    end

    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            r_state       <= ST_INIT;
            r_init_cnt    <= '0;
            for (int unsigned i = 0; i < GROUP_NUM; i++) r_rr[i] <= '0;
            r_busy        <= 1'b0;
            r_addr        <= '0;
            r_unc         <= 1'b0;
            r_resp_word   <= '0;
            r_cop_code    <= '0;
            r_cop_idx     <= '0;
            r_cop_cmp_tag <= '0;
            r_cop_way     <= '0;
            r_cop_tag     <= '0;
            r_cop_v       <= 1'b0;
            r_cop_done    <= 1'b0;
            r_rd_req      <= 1'b0;
            r_rd_uncache  <= 1'b0;
            r_rd_addr     <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + INDEX_W'(1);
                    if (r_init_cnt == INDEX_W'(GROUP_NUM - 1)) r_state <= ST_LOOKUP;
                end
                ST_LOOKUP: begin
                    if (bus.cop_valid && !r_busy) begin
                        r_state       <= ST_COP;
                        r_cop_done    <= 1'b1;
                        r_cop_code    <= bus.cop_code;
                        r_cop_idx     <= bus.cop_addr[OFFSET_W +: INDEX_W];
                        r_cop_cmp_tag <= bus.cop_addr[31 -: TAG_W];
                        r_cop_way     <= (ASSOC_NUM == 1) ? '0
                                         : bus.cop_addr[OFFSET_W+INDEX_W +: WAY_W];
                        r_cop_tag     <= bus.cop_tag;
                        r_cop_v       <= bus.cop_v;
                    end else if (r_busy && !w_lookup_hit) begin
                        r_state      <= ST_MISS;
                        r_rd_req     <= 1'b1;
                        r_rd_uncache <= r_unc;
                        r_rd_addr    <= r_unc ? r_addr : {r_addr[31:OFFSET_W], OFFSET_W'(0)};
                    end else if (bus.req && w_addr_ok) begin
                        r_busy <= 1'b1;
                        r_addr <= bus.addr;
                        r_unc  <= bus.uncached;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_MISS: begin
                    if (bus.rd_rdy) begin
                        r_rd_req <= 1'b0;
                        r_state  <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (bus.ret_valid) begin
                        r_state <= ST_RESP;
                        if (r_unc) begin
                            r_resp_word <= bus.ret_data[31:0];
                        end else begin
                            r_resp_word      <= bus.ret_data[w_word_base +: 32];
                            r_rr[w_req_idx]  <= (w_victim == WAY_W'(ASSOC_NUM - 1)) ? '0
                                                : w_victim + WAY_W'(1);
                        end
                    end
                end
                ST_RESP: begin
                    r_state <= ST_LOOKUP;
                    r_busy  <= 1'b0;
                end
                ST_COP: begin
                    r_state    <= ST_LOOKUP;
                    r_cop_done <= 1'b0;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // Hit data is returned in the compare cycle; refill data one cycle after ret_valid.
    assign bus.addr_ok    = w_addr_ok;
    assign bus.data_ok    = resetn && (w_lookup_hit || (r_state == ST_RESP));
    assign bus.rdata      = !resetn                 ? '0 :
                            w_lookup_hit            ? r_data_q[w_hit_way][w_word_base +: 32] :
                            (r_state == ST_RESP)    ? r_resp_word : '0;
    assign bus.cop_done   = r_cop_done;
    assign bus.rd_req     = r_rd_req;
    assign bus.rd_uncache = r_rd_uncache;
    assign bus.rd_addr    = r_rd_addr;
endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (2 ways, 4-word lines, 256 sets): the bench
// plays the fetch stage and the AXI bridge and checks against hand-computed values.
module tb_icache_nway;
    localparam int unsigned LW = 128;

    logic clk_g = 1'b0;
    logic resetn;
    int   n_chk = 0;
    int   n_err = 0;
    int   waited;

    always #5 clk_g = ~clk_g;

    icache_nway_if #(.TAG_W(20), .LINE_W(LW)) bus ();

    icache_nway #(
        .DATA_WIDTH(32), .LINE_WORD_NUM(4), .ASSOC_NUM(2), .WAY_SIZE(32768)
    ) u_dut (
        .clk_g (clk_g),
        .resetn(resetn),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_g);
        @(negedge clk_g);
    endtask

    function automatic logic [LW-1:0] mkline(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    // One fetch: waits (bounded) for addr_ok, then checks the hit or the full miss path.
    task automatic fetch(input string tag, input logic [31:0] a, input logic unc,
                         input logic hit, input logic [LW-1:0] line,
                         input logic [31:0] exp, output int nwait);
        logic [31:0] exp_rd_addr;
        exp_rd_addr  = unc ? a : {a[31:4], 4'h0};
        bus.req      = 1'b1;
        bus.addr     = a;
        bus.uncached = unc;
        nwait        = 0;
        #1;
        while (!bus.addr_ok && nwait < 400) begin
            cyc();
            #1;
            nwait++;
        end
        check({tag, "_addr_ok"}, 32'(bus.addr_ok), 32'd1);
        cyc();
        bus.req      = 1'b0;
        bus.uncached = 1'b0;
        #1;
        if (hit) begin
            check({tag, "_hit_dok"}, 32'(bus.data_ok), 32'd1);
            check({tag, "_hit_rdata"}, bus.rdata, exp);
            check({tag, "_hit_rdreq"}, 32'(bus.rd_req), 32'd0);
            cyc();
        end else begin
            check({tag, "_miss_dok"}, 32'(bus.data_ok), 32'd0);
            check({tag, "_miss_rdata0"}, bus.rdata, 32'd0);
            cyc();
            #1;
            check({tag, "_rd_req"}, 32'(bus.rd_req), 32'd1);
            check({tag, "_rd_addr"}, bus.rd_addr, exp_rd_addr);
            check({tag, "_rd_unc"}, 32'(bus.rd_uncache), 32'(unc));
            bus.rd_rdy = 1'b1;
            cyc();
            bus.rd_rdy = 1'b0;
            #1;
            check({tag, "_rd_req_drop"}, 32'(bus.rd_req), 32'd0);
            bus.ret_valid = 1'b1;
            bus.ret_data  = line;
            cyc();
            bus.ret_valid = 1'b0;
            #1;
            check({tag, "_resp_dok"}, 32'(bus.data_ok), 32'd1);
            check({tag, "_resp_rdata"}, bus.rdata, exp);
            cyc();
            #1;
            check({tag, "_post_dok"}, 32'(bus.data_ok), 32'd0);
        end
    endtask

    // One CACHE op, optionally with a competing fetch request in the same cycle.
    task automatic cop(input string tag, input logic [1:0] code, input logic [31:0] a,
                       input logic [19:0] t, input logic v, input logic with_req);
        bus.cop_valid = 1'b1;
        bus.cop_code  = code;
        bus.cop_addr  = a;
        bus.cop_tag   = t;
        bus.cop_v     = v;
        if (with_req) begin
            bus.req  = 1'b1;
            bus.addr = a;
        end
        #1;
        check({tag, "_addr_ok0"}, 32'(bus.addr_ok), 32'd0);
        check({tag, "_done_pre"}, 32'(bus.cop_done), 32'd0);
        cyc();
        bus.cop_valid = 1'b0;
        bus.req       = 1'b0;
        #1;
        check({tag, "_done"}, 32'(bus.cop_done), 32'd1);
        check({tag, "_no_dok"}, 32'(bus.data_ok), 32'd0);
        cyc();
        #1;
        check({tag, "_done_post"}, 32'(bus.cop_done), 32'd0);
        check({tag, "_no_rdreq"}, 32'(bus.rd_req), 32'd0);
    endtask

    initial begin
        resetn        = 1'b0;
        bus.req       = 1'b0;
        bus.addr      = '0;
        bus.uncached  = 1'b0;
        bus.cop_valid = 1'b0;
        bus.cop_code  = '0;
        bus.cop_addr  = '0;
        bus.cop_tag   = '0;
        bus.cop_v     = 1'b0;
        bus.rd_rdy    = 1'b0;
        bus.ret_valid = 1'b0;
        bus.ret_data  = '0;

        repeat (3) cyc();
        #1;
        check("rst_addr_ok", 32'(bus.addr_ok), 32'd0);
        check("rst_data_ok", 32'(bus.data_ok), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_cop_done", 32'(bus.cop_done), 32'd0);
        check("rst_rd_req", 32'(bus.rd_req), 32'd0);
        check("rst_rd_unc", 32'(bus.rd_uncache), 32'd0);
        check("rst_rd_addr", bus.rd_addr, 32'd0);
        resetn = 1'b1;

        // INIT sweep of 256 sets, then cold misses into set 0
        fetch("init", 32'h0000_1000, 1'b0, 1'b0, mkline(32'hA5A5_0000), 32'hA5A5_0000, waited);
        check("init_len", 32'(waited), 32'd256);
        fetch("m2008", 32'h0000_2008, 1'b0, 1'b0, mkline(32'hB0B0_0000), 32'hB0B0_0002, waited);

        // back-to-back hits
        bus.req  = 1'b1;
        bus.addr = 32'h0000_1000;
        #1;
        check("b2b_aok0", 32'(bus.addr_ok), 32'd1);
        cyc();
        bus.addr = 32'h0000_1004;
        #1;
        check("b2b_aok1", 32'(bus.addr_ok), 32'd1);
        check("b2b_dok0", 32'(bus.data_ok), 32'd1);
        check("b2b_rd0", bus.rdata, 32'hA5A5_0000);
        cyc();
        bus.addr = 32'h0000_1008;
        #1;
        check("b2b_aok2", 32'(bus.addr_ok), 32'd1);
        check("b2b_dok1", 32'(bus.data_ok), 32'd1);
        check("b2b_rd1", bus.rdata, 32'hA5A5_0001);
        cyc();
        bus.req = 1'b0;
        #1;
        check("b2b_dok2", 32'(bus.data_ok), 32'd1);
        check("b2b_rd2", bus.rdata, 32'hA5A5_0002);
        cyc();
        #1;
        check("b2b_idle_dok", 32'(bus.data_ok), 32'd0);
        check("b2b_idle_rdata", bus.rdata, 32'd0);

        // round-robin in set 1: 0x10->w0, 0x20->w1, 0x30->w0 (evicts 0x10)
        fetch("rr10", 32'h0001_0010, 1'b0, 1'b0, mkline(32'hC100_0000), 32'hC100_0000, waited);
        fetch("rr20", 32'h0002_0010, 1'b0, 1'b0, mkline(32'hC200_0000), 32'hC200_0000, waited);
        fetch("rr30", 32'h0003_0010, 1'b0, 1'b0, mkline(32'hC300_0000), 32'hC300_0000, waited);
        fetch("rr20h", 32'h0002_0014, 1'b0, 1'b1, '0, 32'hC200_0001, waited);
        fetch("rr10m", 32'h0001_0010, 1'b0, 1'b0, mkline(32'hC100_0000), 32'hC100_0000, waited);

        // Index_Invalid way1 set1 kills tag 0x10 only
        cop("idxinv", 2'd0, 32'h0000_1010, 20'h0, 1'b0, 1'b0);
        fetch("ii30h", 32'h0003_0014, 1'b0, 1'b1, '0, 32'hC300_0001, waited);
        fetch("ii10m", 32'h0001_0018, 1'b0, 1'b0, mkline(32'hC100_0000), 32'hC100_0002, waited);

        // uncached fetch, then the same address cached must still miss
        fetch("unc", 32'hBFC0_0004, 1'b1, 1'b0,
              {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'h1234_5678},
              32'h1234_5678, waited);
        fetch("unc_c", 32'hBFC0_0004, 1'b0, 1'b0, mkline(32'hBF00_0000), 32'hBF00_0001, waited);

        // CACHE ops on set 5
        fetch("s5w0", 32'h0000_1050, 1'b0, 1'b0, mkline(32'hD100_0000), 32'hD100_0000, waited);
        fetch("s5w1", 32'h0000_2050, 1'b0, 1'b0, mkline(32'hD200_0000), 32'hD200_0000, waited);
        cop("stag", 2'd1, 32'h0000_1050, 20'h00ABC, 1'b1, 1'b0);
        fetch("stag_h", 32'h00AB_C058, 1'b0, 1'b1, '0, 32'hD200_0002, waited);
        fetch("w0_keep", 32'h0000_1054, 1'b0, 1'b1, '0, 32'hD100_0001, waited);
        cop("hinv", 2'd2, 32'h00AB_C058, 20'h0, 1'b0, 1'b1);
        fetch("hinv_m", 32'h00AB_C058, 1'b0, 1'b0, mkline(32'hE000_0000), 32'hE000_0002, waited);

        // reset while in REFILL; ret_valid during and after reset must be ignored
        bus.req  = 1'b1;
        bus.addr = 32'h0004_0030;
        #1;
        check("rr_aok", 32'(bus.addr_ok), 32'd1);
        cyc();
        bus.req = 1'b0;
        cyc();
        #1;
        check("rr_rdreq", 32'(bus.rd_req), 32'd1);
        bus.rd_rdy = 1'b1;
        cyc();
        bus.rd_rdy    = 1'b0;
        resetn        = 1'b0;
        bus.ret_valid = 1'b1;
        bus.ret_data  = mkline(32'h5555_0000);
        cyc();
        #1;
        check("rr_rst_rdreq", 32'(bus.rd_req), 32'd0);
        check("rr_rst_aok", 32'(bus.addr_ok), 32'd0);
        check("rr_rst_dok", 32'(bus.data_ok), 32'd0);
        resetn = 1'b1;
        cyc();
        #1;
        check("rr_late_dok", 32'(bus.data_ok), 32'd0);
        check("rr_late_rdata", bus.rdata, 32'd0);
        bus.ret_valid = 1'b0;
        fetch("rr_after", 32'h0004_0030, 1'b0, 1'b0, mkline(32'hF000_0000), 32'hF000_0000, waited);
        check("rr_init_len", 32'(waited), 32'd255);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
